// File: rtl/ahb2apb_bridge_gen.sv
// AHB-to-APB bridge: one AHB slave port decoded onto NUM_SLV APB slaves, with APB wait states and error mapping.
// Define BRIDGE_WBUF_EN to post writes through a WBUF_DEPTH-entry FIFO drained in the background.
module ahb2apb_bridge_gen #(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter int                NUM_SLV    = 3,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h8000_0000,
  parameter int                REGION_LSB = 26,
  parameter int                WBUF_DEPTH = 4
) (
  input  logic               Hclk,
  input  logic               Hreset,
  input  logic               Hwrite,
  input  logic               Hreadyin,
  input  logic [1:0]         Htrans,
  input  logic [ADDR_W-1:0]  Haddr,
  input  logic [DATA_W-1:0]  Hwdata,
  output logic               Hreadyout,
  output logic [1:0]         Hresp,
  output logic [DATA_W-1:0]  Hrdata,
  output logic [ADDR_W-1:0]  Paddr,
  output logic [DATA_W-1:0]  Pwdata,
  output logic               Pwrite,
  output logic               Penable,
  output logic [NUM_SLV-1:0] Psel,
  input  logic [DATA_W-1:0]  Prdata,
  input  logic               Pready,
  input  logic               Pslverr,
  output logic               Wbuf_err
);

  localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam logic [NUM_SLV-1:0] ONE = NUM_SLV'(1);

`ifdef BRIDGE_WBUF_EN
  typedef enum logic [3:0] {
    ST_IDLE, ST_WWAIT, ST_SETUP, ST_ACCESS, ST_DONE, ST_ERR1, ST_ERR2, ST_WFULL, ST_RSTALL
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE, ST_WWAIT, ST_SETUP, ST_ACCESS, ST_DONE, ST_ERR1, ST_ERR2
  } state_t;
`endif

  state_t              r_state, w_state_nxt;
  logic                r_hreadyout;
  logic [1:0]          r_hresp;
  logic [DATA_W-1:0]   r_hrdata;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_write;
  logic [IDX_W-1:0]    r_idx;

  logic [ADDR_W-1:0]   w_off;
  logic [ADDR_W-1:0]   w_region;
  logic                w_in_win;
  logic [IDX_W-1:0]    w_idx;
  logic                w_accept;
  logic                w_take;
  logic                w_hready_nxt;
  logic                w_rd_act;

  // Region number is checked on the offset so the upper bound never overflows ADDR_W.
  assign w_off    = Haddr - BASE_ADDR;
  assign w_region = w_off >> REGION_LSB;
  assign w_in_win = (Haddr >= BASE_ADDR) && (w_region < ADDR_W'(NUM_SLV));
  assign w_idx    = w_region[IDX_W-1:0];
  assign w_accept = Hreadyin && Htrans[1] && r_hreadyout;
  assign w_rd_act = (r_state == ST_SETUP) || (r_state == ST_ACCESS);

`ifdef BRIDGE_WBUF_EN
  localparam int PTR_W = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
  localparam int ENT_W = ADDR_W + DATA_W + IDX_W;

  typedef enum logic [1:0] {D_IDLE, D_SETUP, D_ACCESS} dstate_t;

  dstate_t           r_dstate, w_dstate_nxt;
  logic [ENT_W-1:0]  r_mem [WBUF_DEPTH];
  logic [PTR_W-1:0]  r_wp, r_rp;
  logic [PTR_W:0]    r_cnt;
  logic              r_wbuf_err;
  logic              w_push, w_pop, w_full_acc, w_rd_block, w_dr_act, w_fifo_idle;
  logic [ADDR_W-1:0] w_h_addr;
  logic [DATA_W-1:0] w_h_data;
  logic [IDX_W-1:0]  w_h_idx;

  assign {w_h_addr, w_h_data, w_h_idx} = r_mem[r_rp];
  assign w_push      = (r_state == ST_WWAIT);
  assign w_pop       = (r_dstate == D_ACCESS) && Pready;
  // A write still in its data phase occupies a slot it has not pushed yet.
  assign w_full_acc  = (r_cnt == (PTR_W+1)'(WBUF_DEPTH)) ||
                       (w_push && (r_cnt == (PTR_W+1)'(WBUF_DEPTH-1)));
  assign w_dr_act    = (r_dstate != D_IDLE);
  assign w_fifo_idle = (r_cnt == '0) && !w_dr_act;
  assign w_rd_block  = !w_fifo_idle || w_push;

  always_comb begin
    w_dstate_nxt = r_dstate;
    case (r_dstate)
      D_IDLE:   if ((r_cnt != '0) && !w_rd_act) w_dstate_nxt = D_SETUP;
      D_SETUP:  w_dstate_nxt = D_ACCESS;
      D_ACCESS: if (Pready) w_dstate_nxt = D_IDLE;
      default:  w_dstate_nxt = D_IDLE;
    endcase
  end

  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      r_dstate   <= D_IDLE;
      r_wp       <= '0;
      r_rp       <= '0;
      r_cnt      <= '0;
      r_wbuf_err <= 1'b0;
    end else begin
      r_dstate <= w_dstate_nxt;
      if (w_push) r_wp <= r_wp + PTR_W'(1);
      if (w_pop) begin
        r_rp <= r_rp + PTR_W'(1);
        if (Pslverr) r_wbuf_err <= 1'b1;
      end
      r_cnt <= r_cnt + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);
    end
  end

  always_ff @(posedge Hclk) begin
    if (w_push) r_mem[r_wp] <= {r_addr, Hwdata, r_idx};
  end
`else
  logic [DATA_W-1:0] r_pwdata;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_take      = w_accept;
      end
`ifdef BRIDGE_WBUF_EN
      ST_WWAIT: begin
        w_state_nxt = ST_IDLE;
        w_take      = w_accept;
      end
      ST_WFULL:  if (r_cnt != (PTR_W+1)'(WBUF_DEPTH)) w_state_nxt = ST_WWAIT;
      ST_RSTALL: if (w_fifo_idle) w_state_nxt = ST_SETUP;
`else
      ST_WWAIT:  w_state_nxt = ST_SETUP;
`endif
      ST_SETUP:  w_state_nxt = ST_ACCESS;
      ST_ACCESS: if (Pready) w_state_nxt = Pslverr ? ST_ERR1 : ST_DONE;
      ST_ERR1:   w_state_nxt = ST_ERR2;
      // Any accept seen during ERR2 is dropped: the master cancels on an ERROR response.
      ST_ERR2:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
    if (w_take) begin
      if (!w_in_win) begin
        w_state_nxt = ST_ERR1;
      end else if (!Hwrite) begin
`ifdef BRIDGE_WBUF_EN
        w_state_nxt = w_rd_block ? ST_RSTALL : ST_SETUP;
`else
        w_state_nxt = ST_SETUP;
`endif
      end else begin
`ifdef BRIDGE_WBUF_EN
        w_state_nxt = w_full_acc ? ST_WFULL : ST_WWAIT;
`else
        w_state_nxt = ST_WWAIT;
`endif
      end
    end
  end

  always_comb begin
    w_hready_nxt = 1'b0;
    case (w_state_nxt)
      ST_IDLE, ST_DONE, ST_ERR2: w_hready_nxt = 1'b1;
`ifdef BRIDGE_WBUF_EN
      ST_WWAIT: w_hready_nxt = 1'b1;
`endif
      default: w_hready_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      r_state     <= ST_IDLE;
      r_hreadyout <= 1'b1;
      r_hresp     <= 2'b00;
      r_hrdata    <= '0;
      r_addr      <= '0;
      r_write     <= 1'b0;
      r_idx       <= '0;
`ifndef BRIDGE_WBUF_EN
      r_pwdata    <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_hreadyout <= w_hready_nxt;
      r_hresp     <= ((w_state_nxt == ST_ERR1) || (w_state_nxt == ST_ERR2)) ? 2'b01 : 2'b00;
      if (w_take) begin
        r_addr  <= Haddr;
        r_write <= Hwrite;
        r_idx   <= w_idx;
      end
`ifndef BRIDGE_WBUF_EN
      if (r_state == ST_WWAIT) r_pwdata <= Hwdata;
`endif
      if ((r_state == ST_ACCESS) && Pready && !Pslverr && !r_write) r_hrdata <= Prdata;
    end
  end

  assign Hreadyout = r_hreadyout;
  assign Hresp     = r_hresp;
  assign Hrdata    = r_hrdata;

`ifdef BRIDGE_WBUF_EN
  assign Paddr    = w_dr_act ? w_h_addr : r_addr;
  assign Pwdata   = w_dr_act ? w_h_data : '0;
  assign Pwrite   = w_dr_act;
  assign Psel     = w_rd_act ? (ONE << r_idx) : (w_dr_act ? (ONE << w_h_idx) : '0);
  assign Penable  = (r_state == ST_ACCESS) || (r_dstate == D_ACCESS);
  assign Wbuf_err = r_wbuf_err;
`else
  assign Paddr    = r_addr;
  assign Pwdata   = r_pwdata;
  assign Pwrite   = r_write;
  assign Psel     = w_rd_act ? (ONE << r_idx) : '0;
  assign Penable  = (r_state == ST_ACCESS);
  assign Wbuf_err = 1'b0;
`endif

endmodule
